// File: rtl/bin_to_bcd_seq_n_pkg.sv
// Shared types and seven-segment constants for the binary-to-BCD display path.
package bin_to_bcd_seq_n_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] seg;
    seg = SEG_BLANK;
    if (d <= 4'd9) seg = SEG_TABLE[d];
    return seg;
  endfunction

endpackage

// File: rtl/bcd_to_7_seg_n.sv
// N-digit BCD to active-low seven-segment decoder; non-BCD codes show blank.
module bcd_to_7_seg_n
  import bin_to_bcd_seq_n_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0][3:0] bcd,
  output logic [N-1:0][6:0] seg_c
);

  always_comb begin
    seg_c = '0;
    for (int i = 0; i < N; i++) seg_c[i] = seg_digit(bcd[i]);
  end

endmodule

// File: rtl/bin_to_bcd_seq_n.sv
// Sequential double-dabble converter, one bit per cycle, with leading-zero
// blanking and overflow dash display.
module bin_to_bcd_seq_n
  import bin_to_bcd_seq_n_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DIGITS   = 3,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [WIDTH-1:0]        bin,
  output logic                    ready,
  output logic                    done,
  output logic [DIGITS-1:0][3:0]  bcd,
  output logic [DIGITS-1:0][6:0]  hex,
  output logic                    overflow
);

  localparam int unsigned ACC_W = DIGITS * 4;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ACC_W:0]          acc_q, acc_d;
  logic [WIDTH-1:0]        sh_q, sh_d;
  logic [DIGITS-1:0][3:0]  bcd_d;
  logic                    ovf_d, done_d, ready_d;
  logic [ACC_W-1:0]        adj_c;
  logic [DIGITS-1:0][6:0]  seg_c;
  logic                    lead_c;

  // Add-3 correction on every digit >= 5 ahead of the shift
  always_comb begin
    adj_c = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[i*4 +: 4] >= 4'd5) adj_c[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
      else                         adj_c[i*4 +: 4] = acc_q[i*4 +: 4];
    end
  end

  // Next-state and next-output logic; acc MSB is a sticky top-digit carry-out
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    bcd_d   = bcd;
    ovf_d   = overflow;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sh_d    = bin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        acc_d = {acc_q[ACC_W] | adj_c[ACC_W-1], adj_c[ACC_W-2:0], sh_q[WIDTH-1]};
        sh_d  = {sh_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        bcd_d   = acc_q[ACC_W-1:0];
        ovf_d   = acc_q[ACC_W];
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      bcd      <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
      ready    <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      bcd      <= bcd_d;
      overflow <= ovf_d;
      done     <= done_d;
      ready    <= ready_d;
    end
  end

  bcd_to_7_seg_n #(.N(DIGITS)) u_seg (
    .bcd   (bcd),
    .seg_c (seg_c)
  );

  // Display overrides: dash on overflow, else blank zeros above the top nonzero digit
  always_comb begin
    hex    = '0;
    lead_c = BLANK_LZ;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      if (overflow) begin
        hex[i] = SEG_DASH;
      end else if (lead_c && (i != 0) && (bcd[i] == 4'd0)) begin
        hex[i] = SEG_BLANK;
      end else begin
        hex[i] = seg_c[i];
        lead_c = 1'b0;
      end
    end
  end

endmodule
